// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the RV32IM execute unit:
// operation codes, FSM states and M-extension helpers.
package alu_muldiv_seq_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_LUI    = 5'd2;
    localparam logic [4:0] OP_AND    = 5'd3;
    localparam logic [4:0] OP_XOR    = 5'd4;
    localparam logic [4:0] OP_OR     = 5'd5;
    localparam logic [4:0] OP_SLL    = 5'd6;
    localparam logic [4:0] OP_SRL    = 5'd7;
    localparam logic [4:0] OP_SRA    = 5'd8;
    localparam logic [4:0] OP_SLT    = 5'd9;
    localparam logic [4:0] OP_SLTU   = 5'd10;
    localparam logic [4:0] OP_MUL    = 5'd11;
    localparam logic [4:0] OP_MULH   = 5'd12;
    localparam logic [4:0] OP_MULHSU = 5'd13;
    localparam logic [4:0] OP_MULHU  = 5'd14;
    localparam logic [4:0] OP_DIV    = 5'd15;
    localparam logic [4:0] OP_DIVU   = 5'd16;
    localparam logic [4:0] OP_REM    = 5'd17;
    localparam logic [4:0] OP_REMU   = 5'd18;

    // Iterative unit sub-operations: bit 1 selects divide, bit 0 the upper half
    localparam logic [1:0] MD_MUL  = 2'd0;
    localparam logic [1:0] MD_MULH = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;
    localparam logic [1:0] MD_REM  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_muldiv(input logic [4:0] code);
        return (code >= OP_MUL) && (code <= OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv_seq_muldiv_iter.sv
// Iterative multiplier/divider: shift-add multiply and restoring divide
// on operand magnitudes sharing one 2*XLEN accumulator, sign fixed at the end.
module muldiv_iter
    import alu_muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic            sign_a,
    input  logic            sign_b,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    logic [2*XLEN-1:0] acc_q, acc_d, full;
    logic [XLEN-1:0]   opnd_q, ma, mb, diff, half;
    logic [CW-1:0]     cnt_q;
    logic [1:0]        op_q;
    logic              busy_q, neg_q, a_neg, b_neg, ge;
    logic [XLEN:0]     mul_sum, rem_sh;

    assign a_neg = sign_a & a[XLEN-1];
    assign b_neg = sign_b & b[XLEN-1];
    assign ma    = a_neg ? -a : a;
    assign mb    = b_neg ? -b : b;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        ge      = rem_sh >= {1'b0, opnd_q};
        // When ge holds the true difference is below the divisor
        diff    = rem_sh[XLEN-1:0] - opnd_q;
        if (op_q[1])
            acc_d = {ge ? diff : rem_sh[XLEN-1:0], acc_q[XLEN-2:0], ge};
        else
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            op_q   <= MD_MUL;
            busy_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (start) begin
            op_q   <= op;
            cnt_q  <= CW'(XLEN-1);
            busy_q <= 1'b1;
            if (op[1]) begin
                opnd_q <= mb;
                acc_q  <= {{XLEN{1'b0}}, ma};
                // Quotient keeps all-ones on divide by zero
                neg_q  <= op[0] ? a_neg : ((a_neg ^ b_neg) && (b != '0));
            end else begin
                opnd_q <= ma;
                acc_q  <= {{XLEN{1'b0}}, mb};
                neg_q  <= a_neg ^ b_neg;
            end
        end else if (busy_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0)
                busy_q <= 1'b0;
        end
    end

    assign busy = busy_q;
    assign done = busy_q && (cnt_q == '0);

    always_comb begin
        full = neg_q ? -acc_q : acc_q;
        half = op_q[0] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (op_q[1])
            result = neg_q ? -half : half;
        else
            result = op_q[0] ? full[2*XLEN-1:XLEN] : full[XLEN-1:0];
    end

endmodule

// File: rtl/alu_muldiv_seq.sv
// RV32IM execute unit: single-cycle base ALU plus iterative M-extension,
// valid/ready handshake on both sides, one operation in flight.
module alu_muldiv_seq
    import alu_muldiv_seq_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit MULDIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      ALUCode,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            illegal
);

    localparam int SW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, b_q, res_q, res_d, base_res, mdu_res;
    logic [4:0]      code_q;
    logic            ill_q, md_q, valid_q, illo_q;
    logic            in_md, in_ill, accept, load;
    logic            mdu_busy, mdu_done, md_sa, md_sb;
    logic [1:0]      md_op;

    assign in_md  = MULDIV_EN && is_muldiv(ALUCode);
    assign in_ill = (ALUCode > OP_REMU) || (!MULDIV_EN && is_muldiv(ALUCode));
    assign accept = in_valid && in_ready && !flush;

    always_comb begin
        md_op = MD_MUL;
        md_sa = 1'b1;
        md_sb = 1'b1;
        case (ALUCode)
            OP_MULH:   md_op = MD_MULH;
            OP_MULHSU: begin md_op = MD_MULH; md_sb = 1'b0; end
            OP_MULHU:  begin md_op = MD_MULH; md_sa = 1'b0; md_sb = 1'b0; end
            OP_DIV:    md_op = MD_DIV;
            OP_DIVU:   begin md_op = MD_DIV; md_sa = 1'b0; md_sb = 1'b0; end
            OP_REM:    md_op = MD_REM;
            OP_REMU:   begin md_op = MD_REM; md_sa = 1'b0; md_sb = 1'b0; end
            default:   ;
        endcase
    end

    muldiv_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && in_md),
        .op     (md_op),
        .sign_a (md_sa),
        .sign_b (md_sb),
        .a      (A),
        .b      (B),
        .busy   (mdu_busy),
        .done   (mdu_done),
        .result (mdu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            code_q <= OP_ADD;
            ill_q  <= 1'b0;
            md_q   <= 1'b0;
        end else if (accept) begin
            a_q    <= A;
            b_q    <= B;
            code_q <= ALUCode;
            ill_q  <= in_ill;
            md_q   <= in_md;
        end
    end

    always_comb begin
        base_res = '0;
        case (code_q)
            OP_ADD:  base_res = a_q + b_q;
            OP_SUB:  base_res = a_q - b_q;
            OP_LUI:  base_res = b_q;
            OP_AND:  base_res = a_q & b_q;
            OP_XOR:  base_res = a_q ^ b_q;
            OP_OR:   base_res = a_q | b_q;
            OP_SLL:  base_res = a_q << b_q[SW-1:0];
            OP_SRL:  base_res = a_q >> b_q[SW-1:0];
            OP_SRA:  base_res = $signed(a_q) >>> b_q[SW-1:0];
            OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
            OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a_q < b_q};
            default: base_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (accept) state_d = in_md ? S_CALC : S_DONE;
                S_CALC: if (mdu_done || !mdu_busy) state_d = S_DONE;
                S_DONE: if (valid_q && out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready = (state_q == S_IDLE);
        load     = (state_q == S_DONE) && !valid_q;
        res_d    = ill_q ? '0 : (md_q ? mdu_res : base_res);
    end

    // Result registers only move on completion or handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            illo_q  <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            res_q   <= res_d;
            illo_q  <= ill_q;
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign out_valid = valid_q;
    assign ALUResult = res_q;
    assign illegal   = illo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed and random bench for alu_muldiv_seq with a result scoreboard.
module tb_alu_muldiv_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        flush, in_valid, out_ready, in_ready, out_valid, illegal;
    logic [4:0]  code;
    logic [31:0] a, b, res;

    logic        flush8, in_valid8, out_ready8, in_ready8, out_valid8, illegal8;
    logic [4:0]  code8;
    logic [7:0]  a8, b8, res8;

    alu_muldiv_seq #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ALUCode(code), .A(a), .B(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(res), .illegal(illegal)
    );

    alu_muldiv_seq #(.XLEN(8), .MULDIV_EN(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .ALUCode(code8), .A(a8), .B(b8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .ALUResult(res8), .illegal(illegal8)
    );

    typedef struct {
        logic [31:0] res;
        logic        ill;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m8(input logic [4:0] c,
                                      input logic [7:0] x, input logic [7:0] y);
        logic signed [7:0] sx, sy;
        sx = x;
        sy = y;
        case (c)
            5'd0:  return x + y;
            5'd1:  return x - y;
            5'd2:  return y;
            5'd3:  return x & y;
            5'd4:  return x ^ y;
            5'd5:  return x | y;
            5'd6:  return x << y[2:0];
            5'd7:  return x >> y[2:0];
            5'd8:  return 8'(sx >>> y[2:0]);
            5'd9:  return (sx < sy) ? 8'd1 : 8'd0;
            5'd10: return (x < y) ? 8'd1 : 8'd0;
            default: return 8'd0;
        endcase
    endfunction

    function automatic logic ov(input bit w8);
        return w8 ? out_valid8 : out_valid;
    endfunction

    function automatic logic [31:0] obs_res(input bit w8);
        return w8 ? {24'd0, res8} : res;
    endfunction

    // Drives one request; returns #1 after the accepting edge
    task automatic send(input bit w8, input logic [4:0] c,
                        input logic [31:0] x, input logic [31:0] y);
        int n;
        @(negedge clk);
        n = 0;
        while (!(w8 ? in_ready8 : in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", 32'd0, 32'd1);
        if (w8) begin
            code8 = c; a8 = x[7:0]; b8 = y[7:0]; in_valid8 = 1'b1;
        end else begin
            code = c; a = x; b = y; in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_valid8 = 1'b0;
    endtask

    task automatic run(input bit w8, input logic [4:0] c,
                       input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] er, input logic ei,
                       input int lat, input int hold, input string tag);
        int n;
        exp_t e;
        sb.push_back('{er, ei, lat, tag});
        send(w8, c, x, y);
        n = 0;
        while (!ov(w8) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        chk({e.tag, "_lat"}, n, e.lat);
        chk({e.tag, "_res"}, obs_res(w8), e.res);
        chk({e.tag, "_ill"}, {31'd0, w8 ? illegal8 : illegal}, {31'd0, e.ill});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({e.tag, "_hold_res"}, obs_res(w8), e.res);
            chk({e.tag, "_hold_valid"}, {31'd0, ov(w8)}, 32'd1);
            chk({e.tag, "_hold_ready"}, {31'd0, w8 ? in_ready8 : in_ready}, 32'd0);
        end
        if (w8) out_ready8 = 1'b1; else out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        out_ready8 = 1'b0;
        chk({e.tag, "_drop"}, {31'd0, ov(w8)}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        logic [4:0] rc;
        logic [7:0] rx, ry;
        flush = 0; in_valid = 0; out_ready = 0; code = 0; a = 0; b = 0;
        flush8 = 0; in_valid8 = 0; out_ready8 = 0; code8 = 0; a8 = 0; b8 = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", res, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst8_in_ready", {31'd0, in_ready8}, 32'd1);

        run(0, 5'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 0, 1, 0, "add_ovf");
        run(0, 5'd8,  32'h80000000, 32'd36,       32'hF8000000, 0, 1, 0, "sra_shamt");
        run(0, 5'd9,  32'hFFFFFFFF, 32'h1,        32'h1,        0, 1, 0, "slt");
        run(0, 5'd10, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1, 0, "sltu");
        run(0, 5'd1,  32'h0,        32'h1,        32'hFFFFFFFF, 0, 1, 0, "sub");
        run(0, 5'd2,  32'h1234,     32'hABCD0000, 32'hABCD0000, 0, 1, 0, "lui");

        run(0, 5'd11, 32'd6,        32'd7,        32'd42,       0, 33, 0, "mul");
        run(0, 5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        0, 33, 0, "mul_neg");
        run(0, 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        0, 33, 0, "mulh");
        run(0, 5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 33, 0, "mulhu");
        run(0, 5'd13, 32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 0, 33, 0, "mulhsu");

        run(0, 5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 33, 0, "div_ovf");
        run(0, 5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h0,        0, 33, 0, "rem_ovf");
        run(0, 5'd16, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 33, 0, "divu_zero");
        run(0, 5'd18, 32'd5,        32'd0,        32'd5,        0, 33, 0, "remu_zero");
        run(0, 5'd15, 32'd5,        32'd0,        32'hFFFFFFFF, 0, 33, 0, "div_zero");
        run(0, 5'd17, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 0, 33, 0, "rem_zero");
        run(0, 5'd17, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 33, 0, "rem_neg");
        run(0, 5'd15, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33, 0, "div_neg");
        run(0, 5'd16, 32'd100,      32'd7,        32'd14,       0, 33, 0, "divu");

        run(0, 5'd19, 32'd1,        32'd2,        32'd0,        1, 1, 0, "illegal19");
        run(0, 5'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 0, 1, 5, "xor_hold");

        // Flush in the tenth CALC cycle, with a competing request
        send(0, 5'd11, 32'd3, 32'd4);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; code = 5'd0; a = 32'd1; b = 32'd1;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle", {31'd0, in_ready}, 32'd1);
        chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("flush_quiet", seen, 32'd0);
        run(0, 5'd5, 32'h00FF0000, 32'h0000AA00, 32'h00FFAA00, 0, 1, 0, "or_after_flush");

        // Asynchronous reset in the middle of a divide
        send(0, 5'd15, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        chk("calc_busy", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_result", res, 32'd0);
        chk("arst_illegal", {31'd0, illegal}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        run(0, 5'd6, 32'h1, 32'd35, 32'h8, 0, 1, 0, "sll_after_rst");

        run(1, 5'd11, 32'h5, 32'h3, 32'h0, 1, 1, 0, "x8_mul_illegal");
        run(1, 5'd15, 32'h9, 32'h3, 32'h0, 1, 1, 0, "x8_div_illegal");
        run(1, 5'd8,  32'h80, 32'h0B, 32'hF0, 0, 1, 0, "x8_sra");
        for (int i = 0; i < 24; i++) begin
            rc = 5'($urandom_range(0, 10));
            rx = 8'($urandom);
            ry = 8'($urandom);
            run(1, rc, {24'd0, rx}, {24'd0, ry}, {24'd0, m8(rc, rx, ry)},
                0, 1, 0, $sformatf("x8_rand%0d_op%0d", i, rc));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
